// File: rtl/uart_tx_fifo_drain_pkg.sv
// uart_pkg: shared state encoding and line constants for the UART TX/RX blocks.
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_ACK = 3'd2,
    START    = 3'd3,
    DATA     = 3'd4,
    STOP     = 3'd5
  } state_t;

  localparam logic UART_IDLE_LEVEL      = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 217;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_drain_if.sv
// uart_tx_fifo_drain_if: Wishbone-style FIFO pop bus between the TX FIFO and its drain.
`default_nettype none

interface uart_tx_fifo_drain_if #(
  parameter int DW = 8
);
  logic          i_fifo_empty;
  logic          o_wb_pop_stb;
  logic          o_wb_pop_cyc;
  logic          i_wb_pop_stall;
  logic          i_wb_pop_ack;
  logic [DW-1:0] i_wb_pop_data;

  modport master (
    input  i_fifo_empty, i_wb_pop_stall, i_wb_pop_ack, i_wb_pop_data,
    output o_wb_pop_stb, o_wb_pop_cyc
  );

  modport slave (
    output i_fifo_empty, i_wb_pop_stall, i_wb_pop_ack, i_wb_pop_data,
    input  o_wb_pop_stb, o_wb_pop_cyc
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo_drain_baud_tick.sv
// uart_baud_tick: reloadable modulo-CLKS_PER_BIT counter, tick on the last cycle of each bit.
`default_nettype none

module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic reload,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || reload) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops words from the TX FIFO and serialises each as an 8N1 frame on o_tx.
`default_nettype none

module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ACK_TIMEOUT  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  uart_tx_fifo_drain_if.master   bus,
  output logic                   o_tx,
  output logic                   o_busy
);

  localparam int            BW        = (DW > 1) ? $clog2(DW) : 1;
  localparam int            AW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DW - 1);
  localparam logic [AW-1:0] LAST_WAIT = AW'(ACK_TIMEOUT - 1);

  state_t        state, next_state;
  logic [DW-1:0] shreg, shreg_nxt;
  logic [BW-1:0] bit_idx, bit_idx_nxt;
  logic [AW-1:0] wait_cnt, wait_cnt_nxt;
  logic          tx_nxt;
  logic          stb, cyc;
  logic          baud_tick;
  logic          baud_reload;

  assign baud_reload      = (next_state != state);
  assign bus.o_wb_pop_stb = stb;
  assign bus.o_wb_pop_cyc = cyc;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .reload    (baud_reload),
    .tick      (baud_tick)
  );

  // Outputs are registered from the next state, so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      wait_cnt <= '0;
      o_tx     <= UART_IDLE_LEVEL;
      o_busy   <= 1'b0;
      stb      <= 1'b0;
      cyc      <= 1'b0;
    end else begin
      state    <= next_state;
      shreg    <= shreg_nxt;
      bit_idx  <= bit_idx_nxt;
      wait_cnt <= wait_cnt_nxt;
      o_tx     <= tx_nxt;
      o_busy   <= (next_state != IDLE);
      stb      <= (next_state == REQ);
      cyc      <= (next_state == REQ) || (next_state == WAIT_ACK);
    end
  end

  always_comb begin
    next_state   = state;
    shreg_nxt    = shreg;
    bit_idx_nxt  = bit_idx;
    wait_cnt_nxt = wait_cnt;
    tx_nxt       = UART_IDLE_LEVEL;
    case (state)
      IDLE: begin
        if (i_enable && !bus.i_fifo_empty && !bus.i_wb_pop_stall) begin
          next_state = REQ;
        end
      end
      REQ: begin
        next_state   = WAIT_ACK;
        wait_cnt_nxt = '0;
      end
      WAIT_ACK: begin
        if (bus.i_wb_pop_ack) begin
          shreg_nxt  = bus.i_wb_pop_data;
          next_state = START;
          tx_nxt     = 1'b0;
        end else if (wait_cnt == LAST_WAIT) begin
          next_state = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (baud_tick) begin
          next_state  = DATA;
          bit_idx_nxt = '0;
          tx_nxt      = shreg[0];
        end
      end
      DATA: begin
        // shreg[0] is always the bit currently on the line
        tx_nxt = shreg[0];
        if (baud_tick) begin
          if (bit_idx == LAST_BIT) begin
            next_state = STOP;
            tx_nxt     = UART_IDLE_LEVEL;
          end else begin
            shreg_nxt   = shreg >> 1;
            bit_idx_nxt = bit_idx + 1'b1;
            tx_nxt      = shreg_nxt[0];
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: directed self-checking bench, CLKS_PER_BIT=4, FIFO acks 2 cycles after strobe.
`default_nettype none

module tb_uart_tx_fifo_drain;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic tx;
  logic busy;

  uart_tx_fifo_drain_if #(.DW(8)) bus ();

  uart_tx_fifo_drain #(
    .DW           (8),
    .CLKS_PER_BIT (4),
    .ACK_TIMEOUT  (4)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_enable  (enable),
    .bus       (bus),
    .o_tx      (tx),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic [7:0] q[$];
  int   ack_delay = 0;
  logic ack_en    = 1'b1;
  int   stb_count = 0;
  int   adjacent  = 0;
  logic prev_stb  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; FIFO model answers a strobe with ack + data two cycles later.
  task automatic step();
    @(posedge clk);
    #1;
    bus.i_wb_pop_ack = 1'b0;
    if (ack_delay != 0) begin
      ack_delay--;
      if (ack_delay == 0 && ack_en && q.size() > 0) begin
        bus.i_wb_pop_ack  = 1'b1;
        bus.i_wb_pop_data = q.pop_front();
        bus.i_fifo_empty  = (q.size() == 0);
      end
    end
    if (bus.o_wb_pop_stb === 1'b1) begin
      stb_count++;
      if (prev_stb) adjacent++;
      ack_delay = 2;
    end
    prev_stb = bus.o_wb_pop_stb;
  endtask

  // Wait for the start bit, then check all 40 frame cycles; returns on the last stop cycle.
  task automatic check_frame(input logic [7:0] b, input string tag);
    int   waited = 0;
    logic e;
    while (tx !== 1'b0 && waited < 30) begin
      step();
      waited++;
    end
    check({tag, "_start_found"}, tx, 0);
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       e = 1'b0;
      else if (i < 36) e = b[(i - 4) / 4];
      else             e = 1'b1;
      check($sformatf("%s_tx_c%0d", tag, i), tx, e);
      check($sformatf("%s_busy_c%0d", tag, i), busy, 1);
      if (i < 39) step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int n;
    reset_n            = 1'b0;
    enable             = 1'b0;
    bus.i_fifo_empty   = 1'b1;
    bus.i_wb_pop_stall = 1'b0;
    bus.i_wb_pop_ack   = 1'b0;
    bus.i_wb_pop_data  = 8'h00;

    // Reset state
    step();
    step();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_stb", bus.o_wb_pop_stb, 0);
    check("rst_cyc", bus.o_wb_pop_cyc, 0);

    // Single byte 0xA5
    reset_n = 1'b1;
    enable  = 1'b1;
    stb_count = 0;
    q.push_back(8'hA5);
    bus.i_fifo_empty = 1'b0;
    check_frame(8'hA5, "a5");
    step();
    check("a5_busy_after", busy, 0);
    check("a5_tx_after", tx, 1);
    check("a5_stb_count", stb_count, 1);

    // Two bytes back to back
    stb_count = 0;
    adjacent  = 0;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    bus.i_fifo_empty = 1'b0;
    check_frame(8'h00, "b00");
    gap = 0;
    step();
    while (tx === 1'b1 && gap < 20) begin
      gap++;
      step();
    end
    check("b2b_gap", gap, 4);
    check_frame(8'hFF, "bff");
    repeat (6) step();
    check("b2b_stb_count", stb_count, 2);
    check("b2b_adjacent", adjacent, 0);
    check("b2b_busy_after", busy, 0);

    // Stall holds off the strobe
    stb_count = 0;
    bus.i_wb_pop_stall = 1'b1;
    q.push_back(8'h3C);
    bus.i_fifo_empty = 1'b0;
    repeat (10) step();
    check("stall_no_stb", stb_count, 0);
    check("stall_busy", busy, 0);
    bus.i_wb_pop_stall = 1'b0;
    check_frame(8'h3C, "s3c");
    check("stall_stb_count", stb_count, 1);
    step();

    // Disable holds off the strobe
    stb_count = 0;
    enable = 1'b0;
    q.push_back(8'h11);
    bus.i_fifo_empty = 1'b0;
    repeat (10) step();
    check("dis_no_stb", stb_count, 0);
    check("dis_busy", busy, 0);
    enable = 1'b1;
    check_frame(8'h11, "d11");
    check("dis_stb_count", stb_count, 1);
    step();

    // Ack timeout, then retry
    ack_en = 1'b0;
    q.push_back(8'h55);
    bus.i_fifo_empty = 1'b0;
    n = 0;
    step();
    while (bus.o_wb_pop_stb !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("to_stb", bus.o_wb_pop_stb, 1);
    check("to_cyc_req", bus.o_wb_pop_cyc, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("to_cyc_w%0d", i), bus.o_wb_pop_cyc, 1);
      check($sformatf("to_stb_w%0d", i), bus.o_wb_pop_stb, 0);
      check($sformatf("to_tx_w%0d", i), tx, 1);
    end
    step();
    check("to_cyc_drop", bus.o_wb_pop_cyc, 0);
    check("to_busy_idle", busy, 0);
    check("to_tx_idle", tx, 1);
    ack_en = 1'b1;
    step();
    check("to_restb", bus.o_wb_pop_stb, 1);
    check_frame(8'h55, "t55");
    step();

    // Reset in the middle of data bit 3
    q.push_back(8'h0F);
    bus.i_fifo_empty = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 30) begin
      step();
      n++;
    end
    check("rm_start", tx, 0);
    repeat (17) step();
    check("rm_bit3", tx, 1);
    reset_n = 1'b0;
    step();
    check("rm_tx", tx, 1);
    check("rm_busy", busy, 0);
    check("rm_cyc", bus.o_wb_pop_cyc, 0);
    check("rm_stb", bus.o_wb_pop_stb, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rm_tx_hold%0d", i), tx, 1);
    end
    reset_n   = 1'b1;
    ack_delay = 0;
    q.push_back(8'hA3);
    bus.i_fifo_empty = 1'b0;
    check_frame(8'hA3, "ra3");
    step();
    check("ra3_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
Downstream consumer of the Wishbone FIFO pop bus. It pops one word whenever the FIFO reports non-empty and the transmitter is idle, then serialises the word as an 8N1 UART frame on o_tx. It sits between the TX FIFO and the board's serial pin, so the Z80 side can push bytes without waiting on line timing.

Parameters:
DW, 8, data word width; the frame carries DW data bits, LSB first.
CLKS_PER_BIT, 217, i_clk cycles per UART bit (25 MHz / 115200). Minimum 2.
ACK_TIMEOUT, 4, maximum cycles to wait for i_wb_pop_ack after the strobe before abandoning the request.

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  synchronous, active-low reset
i_enable  in  1  when low, no new pop is issued; a frame already in progress completes
i_fifo_empty  in  1  FIFO empty flag
o_wb_pop_stb  out  1  pop request, exactly one cycle wide
o_wb_pop_cyc  out  1  high from strobe until ack or timeout
i_wb_pop_stall  in  1  pop stall from the FIFO; while high, the strobe is held off
i_wb_pop_ack  in  1  pop acknowledge
i_wb_pop_data  in  DW  popped word, sampled in the ack cycle
o_tx  out  1  UART line, idle high
o_busy  out  1  high in every state other than IDLE

Behaviour:
- Reset (i_reset_n sampled low at a rising edge):
  - state=IDLE, o_tx=1, o_busy=0, o_wb_pop_stb=0, o_wb_pop_cyc=0, all counters and the shift register cleared.
  - Reset mid-frame aborts immediately; o_tx returns high in the next cycle.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT_ACK, START, DATA, STOP.
- IDLE -> REQ when i_enable && !i_fifo_empty && !i_wb_pop_stall. In REQ, stb=1 and cyc=1 for exactly one cycle.
- REQ -> WAIT_ACK unconditionally. The strobe is never high on two consecutive cycles.
- WAIT_ACK:
  - cyc=1, stb=0.
  - On i_wb_pop_ack: latch i_wb_pop_data into the shift register and go to START.
  - If ACK_TIMEOUT cycles elapse with no ack: go to IDLE with nothing transmitted.
  - An ack seen in any state other than WAIT_ACK is ignored.
- START: o_tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - Shift out DW bits LSB first, each held CLKS_PER_BIT cycles.
  - Bit index counter 0..DW-1, width $clog2(DW).
- STOP: o_tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1.
  - Reloads to 0 on every state entry and wraps without overflow.
- Frame length: exactly (DW+2)*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back throughput:
  - The next REQ can occur the cycle after STOP exits to IDLE, plus the IDLE decision cycle.
  - Minimum idle gap between frames is therefore (1 + 1 + ack latency) cycles of o_tx=1. No glitch low.
- i_enable falling mid-frame has no effect on the current frame. i_fifo_empty changing after REQ is ignored.
- o_tx never changes except on bit boundaries.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding enum: IDLE=0, REQ=1, WAIT_ACK=2, START=3, DATA=4, STOP=5;
  - UART_IDLE_LEVEL=1'b1;
  - the default CLKS_PER_BIT.
- One natural sub-module: uart_baud_tick. It is a reloadable modulo-CLKS_PER_BIT counter producing a one-cycle tick on the last cycle of each bit. It is reused later by the RX side.

Test Plan:
All scenarios use CLKS_PER_BIT=4, DW=8, with the FIFO model acking 2 cycles after the strobe.
- Reset: hold i_reset_n low 2 cycles -> o_tx=1, o_busy=0, stb=0, cyc=0.
- Single byte 0xA5 in FIFO:
  - one stb pulse;
  - o_tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles;
  - frame is 40 cycles; o_busy falls afterwards.
- Two bytes 0x00, 0xFF queued:
  - two single-cycle strobes, never adjacent;
  - frames back to back with o_tx held high through the gap.
- Stall and disable:
  - i_fifo_empty=0 with i_wb_pop_stall=1 -> no strobe until stall drops;
  - i_enable=0 -> no strobe.
- Timeout: no ack after the strobe -> cyc drops after 4 cycles, o_tx stays 1, FSM back in IDLE, a new stb is issued on the next eligible cycle.
- Reset mid-frame: assert reset during the DATA bit 3 of 0x0F -> o_tx=1 the next cycle, then a clean new frame after reset release.
